// File: rtl/station_cmd_cntrl.sv
// station_cmd_cntrl
// Sequences the barcode station reader for the follower robot. A GO command
// latches a destination station ID and arms motion; a STOP command disarms it.
// While in transit, each barcode ID read is compared against the destination
// and motion is disarmed when the destination is reached. A piezo buzzer is
// driven with a square wave whenever the robot is in transit but blocked.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          synchronous reset, active-high
//   cmd[7:0]     command byte: [7:6] opcode (01 GO, 00 STOP, others ignored),
//                [5:0] destination station ID
//   cmd_rdy      command valid, held by the source until consumed
//   clr_cmd_rdy  consume pulse back to the command source
//   ID[7:0]      barcode ID from the barcode reader
//   ID_vld       barcode ID valid, held by the reader until consumed
//   clr_ID_vld   consume pulse back to the barcode reader
//   OK2Move      obstacle-free indication from proximity logic
//   in_transit   registered; high while heading to a station
//   go           motion enable to the motor controller
//   buzz         buzzer drive
//   buzz_n       complement of buzz
module station_cmd_cntrl #(
    parameter int BUZZ_DIV = 12500,
    parameter int BUZZ_W   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       in_transit,
    output logic       go,
    output logic       buzz,
    output logic       buzz_n
);

    localparam logic [1:0]        OP_STOP  = 2'b00;
    localparam logic [1:0]        OP_GO    = 2'b01;
    localparam logic [BUZZ_W-1:0] BUZZ_TOP = BUZZ_W'(BUZZ_DIV - 1);

    // The FSM has exactly two states, so in_transit itself is the state bit.
    logic              in_transit_r;
    logic [5:0]        dest_id_r;
    logic [BUZZ_W-1:0] buzz_cnt_r;
    logic              buzz_r;

    logic              buzz_en_s;
    logic              id_match_s;

    // Both handshakes consume unconditionally, including ignored commands and
    // IDs read while idle; nothing is consumed while reset is asserted.
    assign clr_cmd_rdy = cmd_rdy & ~rst;
    assign clr_ID_vld  = ID_vld & ~rst;

    // A well-formed station ID has a zero upper field; malformed IDs never match.
    assign id_match_s  = (ID[7:6] == 2'b00) && (ID[5:0] == dest_id_r);

    assign buzz_en_s   = in_transit_r & ~OK2Move;

    assign in_transit  = in_transit_r;
    assign go          = in_transit_r & OK2Move;
    assign buzz        = buzz_r;
    assign buzz_n      = ~buzz_r;

    // Transit state and destination: commands take priority over a coincident
    // barcode ID, which is then consumed without being compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_transit_r <= 1'b0;
            dest_id_r    <= 6'h00;
        end else if (cmd_rdy) begin
            case (cmd[7:6])
                OP_GO: begin
                    dest_id_r    <= cmd[5:0];
                    in_transit_r <= 1'b1;
                end
                OP_STOP: begin
                    in_transit_r <= 1'b0;
                end
                default: begin
                    in_transit_r <= in_transit_r;
                end
            endcase
        end else if (ID_vld && in_transit_r && id_match_s) begin
            in_transit_r <= 1'b0;
        end else begin
            in_transit_r <= in_transit_r;
        end
    end

    // Buzzer divider: toggles buzz every BUZZ_DIV cycles while blocked in
    // transit, and parks at zero as soon as the blocking condition clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            buzz_cnt_r <= {BUZZ_W{1'b0}};
            buzz_r     <= 1'b0;
        end else if (!buzz_en_s) begin
            buzz_cnt_r <= {BUZZ_W{1'b0}};
            buzz_r     <= 1'b0;
        end else if (buzz_cnt_r == BUZZ_TOP) begin
            buzz_cnt_r <= {BUZZ_W{1'b0}};
            buzz_r     <= ~buzz_r;
        end else begin
            buzz_cnt_r <= buzz_cnt_r + {{(BUZZ_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_station_cmd_cntrl.sv
// Scoreboard bench for station_cmd_cntrl: each stimulus cycle pushes the
// expected outputs computed by a behavioural model; a negedge monitor pops
// and compares them against the DUT.
module tb_station_cmd_cntrl;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;
    logic       OK2Move;
    logic       in_transit;
    logic       go;
    logic       buzz;
    logic       buzz_n;

    station_cmd_cntrl #(.BUZZ_DIV(DIV), .BUZZ_W(4)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .ID(ID), .ID_vld(ID_vld),
        .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move), .in_transit(in_transit),
        .go(go), .buzz(buzz), .buzz_n(buzz_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic it;
        logic go;
        logic ccr;
        logic civ;
        logic bz;
        logic bzn;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: robot state after the most recent edge.
    bit       m_transit = 1'b0;
    bit [5:0] m_dest    = 6'h00;
    int       m_blocked = 0;   // consecutive edges spent blocked in transit

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("in_transit",  in_transit,  e.it);
            check("go",          go,          e.go);
            check("clr_cmd_rdy", clr_cmd_rdy, e.ccr);
            check("clr_ID_vld",  clr_ID_vld,  e.civ);
            check("buzz",        buzz,        e.bz);
            check("buzz_n",      buzz_n,      e.bzn);
        end
    end

    task automatic step(input logic r, input logic cr, input logic [7:0] c,
                        input logic iv, input logic [7:0] i, input logic ok);
        exp_t e;
        bit   was_transit;
        rst = r; cmd_rdy = cr; cmd = c; ID_vld = iv; ID = i; OK2Move = ok;
        e.it  = m_transit;
        e.go  = m_transit & ok;
        e.ccr = cr & ~r;
        e.civ = iv & ~r;
        // Square wave of half-period DIV counted from when blocking began.
        e.bz  = ((m_blocked / DIV) % 2) == 1;
        e.bzn = ~e.bz;
        sb.push_back(e);
        @(posedge clk);
        was_transit = m_transit;
        if (r) begin
            m_transit = 1'b0;
            m_dest    = 6'h00;
            m_blocked = 0;
        end else begin
            m_blocked = (was_transit && !ok) ? m_blocked + 1 : 0;
            if (cr) begin
                if (c[7:6] == 2'b01) begin
                    m_transit = 1'b1;
                    m_dest    = c[5:0];
                end else if (c[7:6] == 2'b00) begin
                    m_transit = 1'b0;
                end
            end else if (iv && was_transit && i == {2'b00, m_dest}) begin
                m_transit = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ok);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, ok);
    endtask

    initial begin
        logic [7:0] rc;
        logic [7:0] ri;
        logic       rok;
        rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h00; ID_vld = 1'b0; ID = 8'h00; OK2Move = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, then reset held with a pending command.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        idle(1, 1'b1);

        // GO to 1A, reach it.
        step(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        idle(3, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h1A, 1'b1);
        idle(2, 1'b1);

        // GO to 07; wrong station, malformed ID, then the destination.
        step(1'b0, 1'b1, 8'h47, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h1A, 1'b1);
        idle(1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h47, 1'b1);
        idle(1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1);
        idle(2, 1'b1);

        // GO then STOP; ID in IDLE discarded; ignored opcode.
        step(1'b0, 1'b1, 8'h47, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1);
        step(1'b0, 1'b1, 8'hC5, 1'b0, 8'h00, 1'b1);
        idle(2, 1'b1);

        // Blocked in transit: buzzer runs, then stops when clear.
        step(1'b0, 1'b1, 8'h47, 1'b0, 8'h00, 1'b1);
        idle(40, 1'b0);
        idle(3, 1'b1);

        // Coincident GO (same dest) and matching ID: command wins.
        step(1'b0, 1'b1, 8'h47, 1'b1, 8'h07, 1'b1);
        idle(2, 1'b1);

        // Reset mid-transit with pending command and ID, processed afterwards.
        idle(3, 1'b0);
        step(1'b1, 1'b1, 8'h43, 1'b1, 8'h03, 1'b0);
        step(1'b0, 1'b1, 8'h43, 1'b1, 8'h03, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1);
        idle(2, 1'b1);

        // Randomised traffic over a small station set so matches are frequent.
        rok = 1'b1;
        for (int n = 0; n < 800; n++) begin
            rc = {$urandom_range(3, 0) == 0 ? 2'b00 : ($urandom_range(3, 0) == 0 ? 2'b11 : 2'b01),
                  3'b000, 3'($urandom_range(7, 0))};
            ri = {($urandom_range(7, 0) == 0) ? 2'b01 : 2'b00, 3'b000, 3'($urandom_range(7, 0))};
            if ($urandom_range(24, 0) == 0) rok = ~rok;
            step(($urandom_range(99, 0) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(5, 0) == 0) ? 1'b1 : 1'b0, rc,
                 ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0, ri, rok);
        end
        idle(2, 1'b1);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/station_cmd_cntrl.md
Name: station_cmd_cntrl

Overview:
- Sequences the barcode station reader for the follower robot.
- Accepts go/stop commands from the command receiver (cmd/cmd_rdy), latches a destination station ID, and arms motion.
- Consumes barcode IDs (ID/ID_vld) as they are read, clearing them, and stops when the destination station is seen.
- Drives a piezo buzzer while in transit but blocked (OK2Move low).

Parameters:
BUZZ_DIV, 12500, clk cycles per buzzer half-period (toggle interval); must be >= 2
BUZZ_W, 15, width of buzzer divide counter; must satisfy 2**BUZZ_W >= BUZZ_DIV

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
cmd  input  8  command byte; [7:6] opcode, [5:0] station ID
cmd_rdy  input  1  cmd valid; held high by source until clr_cmd_rdy
clr_cmd_rdy  output  1  consume pulse to command source
ID  input  8  barcode ID from barcode reader
ID_vld  input  1  ID valid; held high by reader until clr_ID_vld
clr_ID_vld  output  1  consume pulse to barcode reader
OK2Move  input  1  obstacle-free indication from proximity logic
in_transit  output  1  registered; high while heading to a station
go  output  1  motion enable to motor controller
buzz  output  1  buzzer drive
buzz_n  output  1  complement of buzz

Behaviour:
- Reset (rst high at a clock edge):
  - in_transit=0, dest_ID=6'h00, buzz counter=0, buzz=0, buzz_n=1.
  - clr_cmd_rdy=0 and clr_ID_vld=0 while rst high.
- States, encoded by in_transit:
  - IDLE (in_transit=0)
  - MOVING (in_transit=1)
- Command consume:
  - clr_cmd_rdy = cmd_rdy & ~rst, combinational, in both states.
  - Every command is consumed, including ignored ones.
  - Source drops cmd_rdy on the edge after clr_cmd_rdy, so each command is seen exactly one cycle.
- Opcode decode, applied at the clock edge where cmd_rdy=1:
  - 2'b01 GO: dest_ID <= cmd[5:0]; in_transit <= 1. Valid from IDLE and from MOVING (retargets; stays MOVING).
  - 2'b00 STOP: in_transit <= 0; dest_ID unchanged.
  - 2'b10 / 2'b11: ignored, no state change.
- ID consume:
  - clr_ID_vld = ID_vld & ~rst, combinational, in both states. IDs in IDLE are discarded.
- Station match, in MOVING with ID_vld=1 and no cmd_rdy the same cycle:
  - If ID[7:6]==2'b00 and ID[5:0]==dest_ID: in_transit <= 0, so IDLE starts the next cycle.
  - Otherwise (wrong station, or malformed ID[7:6]!=00): stay MOVING.
- Simultaneous cmd_rdy and ID_vld:
  - The command has priority; the ID is still cleared but not compared.
  - GO to the same dest as the coincident ID does not stop.
- Motion enable:
  - go = in_transit & OK2Move, combinational.
  - go goes low the same cycle OK2Move drops; it returns without re-command when OK2Move rises.
- Buzzer:
  - Active condition: buzz_en = in_transit & ~OK2Move.
  - When buzz_en=0: counter <= 0, buzz <= 0.
  - When buzz_en=1: counter increments each cycle. At counter==BUZZ_DIV-1, counter wraps to 0 and buzz toggles.
  - First toggle occurs BUZZ_DIV cycles after buzz_en rises; the square wave has period 2*BUZZ_DIV.
  - buzz_n = ~buzz (registered or derived; must never equal buzz).
  - Leaving MOVING or OK2Move returning high stops the buzzer on the next edge with buzz=0.
- Reset mid-operation: rst during MOVING returns to the reset state at that edge. Pending cmd_rdy/ID_vld are not cleared while rst is high; they are processed after rst drops.
- No internal latency beyond one edge: state, dest and buzzer updates occur at the edge that samples the input.

Test Plan:
- Reset with cmd_rdy=0, ID_vld=0 -> in_transit=0, go=0, buzz=0, buzz_n=1. Hold rst with cmd_rdy=1 -> clr_cmd_rdy=0.
- cmd=8'h5A (GO, dest 6'h1A), OK2Move=1 -> clr_cmd_rdy high 1 cycle, in_transit=1 next cycle, go=1. Then ID=8'h1A from barcode_mimic (period 22'h400) -> clr_ID_vld pulse, in_transit=0 and go=0 the cycle after.
- GO dest 6'h07, then IDs 8'h1A, 8'h47 (malformed), 8'h07 -> each clr_ID_vld pulses; stays MOVING through 1A and 47; stops after 07.
- GO dest 6'h07, then STOP cmd=8'h00 -> in_transit=0. Later ID=8'h07 -> cleared, no state change. Opcode 8'hC5 in IDLE -> consumed, stays IDLE.
- BUZZ_DIV=8, MOVING, OK2Move=0 for 40 cycles -> go=0; buzz first rises 8 cycles after OK2Move falls, then toggles every 8 cycles; buzz_n always complement. OK2Move=1 -> buzz=0 next cycle, go=1.
- MOVING dest 6'h07, same cycle cmd=8'h47 and ID=8'h07 -> both cleared; stays MOVING (command priority).
